dense_layer: RTL and testbench
==============================

Name: dense_layer

Overview:
- Fully-connected layer that directly consumes the flattened feature vector produced by the flatten stage.
- Computes OUT_LEN signed dot products, one multiply-accumulate per cycle, against weights and biases held in an external synchronous memory.
- Each result is requantised with optional ReLU, then the full output vector is presented to the next layer or classifier with a done pulse.

Parameters:
- IN_LEN, 16, number of elements in the input vector.
- OUT_LEN, 4, number of output neurons.
- DATA_W, 8, signed width of activations, weights and biases (two's complement).
- ACC_W, 32, signed accumulator width.
- FRAC_BITS, 0, fractional bits of the shared Q format.
- RELU_EN, 1, 1 = clamp negative results to 0.
- WADDR_W, $clog2(OUT_LEN*IN_LEN+OUT_LEN), width of the weight-memory address.

Ports:
- clk  in  1  single clock; everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse that requests one inference.
- in_vector  in  IN_LEN*DATA_W  flattened activations; element i is [i*DATA_W +: DATA_W].
- weight_addr  out  WADDR_W  read address to the weight memory.
- weight_data  in  DATA_W  read data, valid 1 cycle after weight_addr.
- out_vector  out  OUT_LEN*DATA_W  results; neuron o is [o*DATA_W +: DATA_W].
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when out_vector is updated.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; out_vector=0; done=0; busy=0; weight_addr=0; accumulator, counters and internal result registers cleared. Reset mid-operation aborts the run immediately, with no partial out_vector update.
- Memory map:
  - weight for (o,i) is at address o*IN_LEN+i.
  - bias for o is at address OUT_LEN*IN_LEN+o.
- IDLE:
  - start=1 latches in_vector into an internal register, clears the accumulator, sets o=0, i=0, and moves to MAC.
  - start while not in IDLE is ignored.
  - in_vector changes after acceptance have no effect.
- MAC (IN_LEN cycles per neuron):
  - Issue weight_addr=o*IN_LEN+i each cycle; i increments each cycle.
  - A 1-cycle-delayed valid/index pipeline adds x[i_d]*weight_data, a signed full product sign-extended to ACC_W, into the accumulator.
  - After issuing i=IN_LEN-1, move to BIAS.
- BIAS (1 cycle): issue the bias address while the last product accumulates.
- WB (1 cycle), in order:
  - acc + (sign-extended bias <<< FRAC_BITS);
  - arithmetic shift right by FRAC_BITS (truncation toward -inf);
  - saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1];
  - if RELU_EN, negative results become 0.
  - The result is stored in internal slot o and the accumulator is cleared.
  - If o=OUT_LEN-1, go to DONE; else o++, i=0, go to MAC.
- DONE (1 cycle): copy all internal slots to out_vector atomically, done=1, busy=0, then IDLE.
- out_vector holds its previous value during a run.
- start in the DONE cycle is ignored; start in the next (IDLE) cycle is accepted, so back-to-back runs are possible.
- Latency: done is high exactly OUT_LEN*(IN_LEN+2)+1 cycles after the start edge (73 with defaults).
- Accumulator overflow is not detected; ACC_W must be at least 2*DATA_W+$clog2(IN_LEN)+1+FRAC_BITS. Width violations fail at elaboration.
- weight_addr holds its last value outside MAC/BIAS.

Decomposition:
- Shared package (cnn_pkg): state enum {IDLE, MAC, BIAS, WB, DONE}; saturation min/max constants derived from DATA_W; address-map helper functions (weight base, bias base).
- One sub-module, dense_requant: combinational bias-add, shift, saturate and ReLU (ACC_W in, DATA_W out), reusable by the conv layers.
- The FSM, counters and MAC pipeline stay in dense_layer.

Test Plan (IN_LEN=4, OUT_LEN=2, DATA_W=8 unless noted):
- Basic run, FRAC_BITS=0, RELU_EN=0, x={1,2,3,4}, w0={1,1,1,1} b0=0, w1={-1,-1,-1,-1} b1=2 -> out={10,-8}; done exactly 13 cycles after start; busy high the cycle after start through the cycle before done.
- Same stimulus with RELU_EN=1 -> out={10,0}.
- Saturation: x all 100, w all 100, b=0 -> both outputs 127. x all 100, w all -100 with RELU_EN=0 -> both -128.
- Fixed point, FRAC_BITS=4: x all 16 (1.0), w0 all 8 (0.5) b0=16, w1 all 8 b1=0 -> out={48,32}.
- Control:
  - start pulsed mid-run -> ignored; done count is 1 and out_vector is unchanged until done.
  - rst asserted at cycle 6 -> out_vector=0, busy=0, no done; a fresh start then gives the basic-run result.
- Back-to-back: second start in the cycle after done, with new x={0,0,0,1} -> out={1,1} (RELU_EN=1, basic weights), i.e. 1 and max(-1+2,0)=1.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN types, FSM state encoding and address/saturation helpers.
// Imported by the dense layer and its requantiser.
package cnn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MAC,
    BIAS,
    WB,
    DONE
  } state_e;

  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

  function automatic int weight_base(input int o, input int in_len);
    return o * in_len;
  endfunction

  function automatic int bias_base(input int out_len, input int in_len);
    return out_len * in_len;
  endfunction

  function automatic int acc_min_w(input int data_w, input int in_len,
                                   input int frac);
    return 2 * data_w + $clog2(in_len) + 1 + frac;
  endfunction

endpackage

// File: rtl/dense_requant.sv
// Combinational requantiser: bias add, arithmetic shift, saturate, ReLU.
// Ports: acc_i (ACC_W accumulator), bias_i (DATA_W bias), res_o (DATA_W result).
module dense_requant
  import cnn_pkg::*;
#(
  parameter int ACC_W     = 32,
  parameter int DATA_W    = 8,
  parameter int FRAC_BITS = 0,
  parameter int RELU_EN   = 1
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  input  logic signed [DATA_W-1:0] bias_i,
  output logic signed [DATA_W-1:0] res_o
);

  localparam logic signed [ACC_W-1:0] MAX = ACC_W'(sat_max(DATA_W));
  localparam logic signed [ACC_W-1:0] MIN = ACC_W'(sat_min(DATA_W));

  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] shr;

  always_comb begin
    bias_ext = {{(ACC_W-DATA_W){bias_i[DATA_W-1]}}, bias_i};
    // Bias is aligned to the accumulator's Q format before the add.
    sum = acc_i + (bias_ext <<< FRAC_BITS);
    shr = sum >>> FRAC_BITS;
    if (shr > MAX) begin
      res_o = MAX[DATA_W-1:0];
    end else if (shr < MIN) begin
      res_o = MIN[DATA_W-1:0];
    end else begin
      res_o = shr[DATA_W-1:0];
    end
    if ((RELU_EN != 0) && res_o[DATA_W-1]) begin
      res_o = '0;
    end
  end

endmodule

// File: rtl/dense_layer.sv
// Fully-connected layer: one MAC per cycle against external weight memory.
// Ports: clk, rst, start, in_vector, weight_addr/weight_data, out_vector, busy, done.
module dense_layer
  import cnn_pkg::*;
#(
  parameter int IN_LEN    = 16,
  parameter int OUT_LEN   = 4,
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 32,
  parameter int FRAC_BITS = 0,
  parameter int RELU_EN   = 1,
  parameter int WADDR_W   = $clog2(OUT_LEN*IN_LEN+OUT_LEN)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [IN_LEN*DATA_W-1:0]  in_vector,
  output logic [WADDR_W-1:0]        weight_addr,
  input  logic [DATA_W-1:0]         weight_data,
  output logic [OUT_LEN*DATA_W-1:0] out_vector,
  output logic                      busy,
  output logic                      done
);

  localparam int IW    = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
  localparam int OW    = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
  localparam int PW    = 2 * DATA_W;
  localparam int BIAS0 = bias_base(OUT_LEN, IN_LEN);

  if (ACC_W < acc_min_w(DATA_W, IN_LEN, FRAC_BITS)) begin : g_acc_chk
    $error("dense_layer: ACC_W too narrow");
  end

  state_e                    state_q;
  logic [IN_LEN*DATA_W-1:0]  x_q;
  logic [OW-1:0]             o_q;
  logic [IW-1:0]             i_q;
  logic [IW-1:0]             idx_q;
  logic                      v_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic [OUT_LEN*DATA_W-1:0] slot_q;
  logic [OUT_LEN*DATA_W-1:0] out_q;
  logic [WADDR_W-1:0]        addr_q;
  logic                      busy_q;
  logic                      done_q;

  logic signed [DATA_W-1:0]  xsel_d;
  logic signed [PW-1:0]      prod_d;
  logic signed [ACC_W-1:0]   acc_d;
  logic signed [DATA_W-1:0]  rq_d;

  // Product uses the index delayed to line up with weight_data.
  always_comb begin
    xsel_d = x_q[idx_q*DATA_W +: DATA_W];
    prod_d = xsel_d * $signed(weight_data);
    acc_d  = acc_q + {{(ACC_W-PW){prod_d[PW-1]}}, prod_d};
  end

  dense_requant #(
    .ACC_W    (ACC_W),
    .DATA_W   (DATA_W),
    .FRAC_BITS(FRAC_BITS),
    .RELU_EN  (RELU_EN)
  ) u_requant (
    .acc_i (acc_q),
    .bias_i($signed(weight_data)),
    .res_o (rq_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      o_q     <= '0;
      i_q     <= '0;
      idx_q   <= '0;
      v_q     <= 1'b0;
      acc_q   <= '0;
      slot_q  <= '0;
      out_q   <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      v_q    <= (state_q == MAC);
      idx_q  <= i_q;
      if (v_q) begin
        acc_q <= acc_d;
      end
      unique case (state_q)
        IDLE: begin
          if (start) begin
            x_q     <= in_vector;
            acc_q   <= '0;
            o_q     <= '0;
            i_q     <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= MAC;
          end
        end
        MAC: begin
          if (i_q == IW'(IN_LEN-1)) begin
            addr_q  <= WADDR_W'(BIAS0 + int'(o_q));
            state_q <= BIAS;
          end else begin
            i_q    <= i_q + IW'(1);
            addr_q <= addr_q + WADDR_W'(1);
          end
        end
        BIAS: begin
          state_q <= WB;
        end
        WB: begin
          slot_q[o_q*DATA_W +: DATA_W] <= rq_d;
          acc_q <= '0;
          if (o_q == OW'(OUT_LEN-1)) begin
            state_q <= DONE;
          end else begin
            o_q     <= o_q + OW'(1);
            i_q     <= '0;
            addr_q  <= WADDR_W'(weight_base(int'(o_q) + 1, IN_LEN));
            state_q <= MAC;
          end
        end
        DONE: begin
          out_q   <= slot_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign weight_addr = addr_q;
  assign out_vector  = out_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_dense_layer.sv
// Scoreboard bench for dense_layer: three configurations share one clock.
// u0: plain, u1: ReLU, u2: Q4 fixed point.
module tb_dense_layer;

  logic        clk;
  logic        rst   [3];
  logic        start [3];
  logic [31:0] inv   [3];
  logic [3:0]  wa    [3];
  logic [7:0]  wd    [3];
  logic [15:0] outv  [3];
  logic        busy  [3];
  logic        done  [3];

  logic [7:0]  mem [3][16];
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] q2[$];
  int          dcnt [3];
  int          checks;
  int          errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dense_layer #(
    .IN_LEN(4), .OUT_LEN(2), .DATA_W(8), .ACC_W(32),
    .FRAC_BITS(0), .RELU_EN(0)
  ) u0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .in_vector(inv[0]),
    .weight_addr(wa[0]), .weight_data(wd[0]), .out_vector(outv[0]),
    .busy(busy[0]), .done(done[0])
  );

  dense_layer #(
    .IN_LEN(4), .OUT_LEN(2), .DATA_W(8), .ACC_W(32),
    .FRAC_BITS(0), .RELU_EN(1)
  ) u1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .in_vector(inv[1]),
    .weight_addr(wa[1]), .weight_data(wd[1]), .out_vector(outv[1]),
    .busy(busy[1]), .done(done[1])
  );

  dense_layer #(
    .IN_LEN(4), .OUT_LEN(2), .DATA_W(8), .ACC_W(32),
    .FRAC_BITS(4), .RELU_EN(0)
  ) u2 (
    .clk(clk), .rst(rst[2]), .start(start[2]), .in_vector(inv[2]),
    .weight_addr(wa[2]), .weight_data(wd[2]), .out_vector(outv[2]),
    .busy(busy[2]), .done(done[2])
  );

  // Synchronous weight memories: data one cycle after address.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) wd[k] <= mem[k][wa[k]];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [15:0] e);
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Monitor: every done pops one expectation for that instance.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (done[k] === 1'b1) begin
        logic [15:0] e;
        bit          have;
        dcnt[k]++;
        have = 1'b0;
        e    = '0;
        case (k)
          0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1; end
          1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1; end
          default:
             if (q2.size() > 0) begin e = q2.pop_front(); have = 1; end
        endcase
        if (!have) chk($sformatf("unexpected_done_u%0d", k), 1, 0);
        else chk($sformatf("out_u%0d", k), 32'(outv[k]), 32'(e));
      end
    end
  end

  task automatic load(input int k, input logic [31:0] w0,
                      input logic [7:0] b0, input logic [31:0] w1,
                      input logic [7:0] b1);
    for (int a = 0; a < 16; a++) mem[k][a] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      mem[k][i]     = w0[i*8 +: 8];
      mem[k][4 + i] = w1[i*8 +: 8];
    end
    mem[k][8] = b0;
    mem[k][9] = b1;
  endtask

  // One inference; returns on the negedge where done is seen.
  task automatic run(input int k, input logic [31:0] x,
                     input logic [15:0] e, input int mid_n,
                     input logic [31:0] x_late);
    logic [15:0] prev;
    int          n;
    bit          got;
    bit          busy_ok;
    bit          hold_ok;
    push(k, e);
    inv[k] = x;
    @(negedge clk);
    prev = outv[k];
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
    busy_ok = (busy[k] === 1'b1);
    hold_ok = 1'b1;
    got = 1'b0;
    n = 0;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      start[k] = (n == mid_n);
      if (n == 2) inv[k] = x_late;
      if (done[k] === 1'b1) begin
        got = 1'b1;
        if (busy[k] !== 1'b0) busy_ok = 1'b0;
      end else begin
        if (busy[k] !== 1'b1) busy_ok = 1'b0;
        if (outv[k] !== prev) hold_ok = 1'b0;
      end
    end
    start[k] = 1'b0;
    chk($sformatf("done_seen_u%0d", k), 32'(got), 1);
    chk($sformatf("latency_u%0d", k), n, 13);
    chk($sformatf("busy_u%0d", k), 32'(busy_ok), 1);
    chk($sformatf("hold_u%0d", k), 32'(hold_ok), 1);
  endtask

  task automatic run_rst(input int k, input logic [31:0] x);
    int d0;
    d0 = dcnt[k];
    inv[k] = x;
    @(negedge clk);
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
    repeat (6) @(negedge clk);
    rst[k] = 1'b1;
    @(negedge clk);
    rst[k] = 1'b0;
    chk("rst_out", 32'(outv[k]), 0);
    chk("rst_busy", 32'(busy[k]), 0);
    repeat (25) @(negedge clk);
    chk("rst_nodone", dcnt[k] - d0, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int d0;
    checks = 0;
    errors = 0;
    for (int k = 0; k < 3; k++) begin
      rst[k]   = 1'b1;
      start[k] = 1'b0;
      inv[k]   = '0;
      dcnt[k]  = 0;
      for (int a = 0; a < 16; a++) mem[k][a] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_out_u%0d", k), 32'(outv[k]), 0);
      chk($sformatf("reset_busy_u%0d", k), 32'(busy[k]), 0);
      chk($sformatf("reset_done_u%0d", k), 32'(done[k]), 0);
      chk($sformatf("reset_addr_u%0d", k), 32'(wa[k]), 0);
    end

    // Basic: x={1,2,3,4}, w0=1s b0=0, w1=-1s b1=2.
    load(0, 32'h01010101, 8'd0, 32'hFFFFFFFF, 8'd2);
    load(1, 32'h01010101, 8'd0, 32'hFFFFFFFF, 8'd2);
    run(0, 32'h04030201, 16'hF80A, 0, 32'h04030201);
    run(1, 32'h04030201, 16'h000A, 0, 32'h04030201);

    // Saturation both ways.
    load(0, 32'h64646464, 8'd0, 32'h64646464, 8'd0);
    run(0, 32'h64646464, 16'h7F7F, 0, 32'h64646464);
    load(0, 32'h9C9C9C9C, 8'd0, 32'h9C9C9C9C, 8'd0);
    run(0, 32'h64646464, 16'h8080, 0, 32'h64646464);

    // Q4: x=1.0, w=0.5, b0=1.0 -> {3.0, 2.0}.
    load(2, 32'h08080808, 8'd16, 32'h08080808, 8'd0);
    run(2, 32'h10101010, 16'h2030, 0, 32'h10101010);

    // Start pulsed mid-run is ignored.
    load(0, 32'h01010101, 8'd0, 32'hFFFFFFFF, 8'd2);
    d0 = dcnt[0];
    run(0, 32'h04030201, 16'hF80A, 5, 32'h04030201);
    repeat (20) @(negedge clk);
    chk("mid_start_done_cnt", dcnt[0] - d0, 1);

    // Reset mid-run, then a clean run.
    run_rst(0, 32'h04030201);
    run(0, 32'h04030201, 16'hF80A, 0, 32'h04030201);

    // in_vector changed after acceptance, then back-to-back run.
    run(1, 32'h04030201, 16'h000A, 0, 32'h01000000);
    run(1, 32'h01000000, 16'h0101, 0, 32'h01000000);

    repeat (5) @(negedge clk);
    chk("queues_empty", q0.size() + q1.size() + q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
